quant_tile_seq: RTL and testbench
=================================

# quant_tile_seq

Two-pass tile sequencer for the activation quantisation stage. It buffers one tile of fp32 activations, finds the largest magnitude in the tile, then replays the tile through the `quant_pre` stage using that maximum as the scale reference. Results are presented on a valid/ready stream. It sits between the activation producer and the integer MAC/packing logic.

## Interface
- `DEPTH`, 64: maximum tile length in words; must be a power of 2.
- `AW`, `$clog2(DEPTH)`: buffer address width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain.
- `i_start`  in  1  start a tile; sampled only in IDLE.
- `i_len`  in  AW+1  tile length, 0..DEPTH; sampled with `i_start`.
- `i_valid`  in  1  input activation valid.
- `i_data`  in  32  fp32 activation.
- `o_in_ready`  out  1  input accept; transfer happens when `i_valid & o_in_ready`.
- `q_max`  out  32  to `quant_pre.i_max`.
- `q_act`  out  32  to `quant_pre.i_activation`.
- `q_unit`  in  32  from `quant_pre.o_unit`.
- `q_act_res`  in  32  from `quant_pre.o_activation`.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  downstream accept.
- `o_unit`  out  32  unit word of the head result.
- `o_activation`  out  32  quantised activation of the head result.
- `o_last`  out  1  head result is the final element of the tile.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse at tile completion.

## Operation
- States: IDLE -> LOAD -> REPLAY -> DRAIN -> IDLE.
- IDLE: on `i_start`, latch `i_len` and clear the max register to 0.
  - `i_len == 0`: pulse `o_done` on the next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD: `o_in_ready = 1`. Each accepted word is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - Max update: compare `i_data[30:0]` against `max[30:0]` as unsigned; on strictly greater, store the full word including the sign.
  - Equal magnitudes keep the earlier word.
  - After `i_len` words, go to REPLAY.
- REPLAY:
  - `q_max = max` (constant for the whole pass); `q_act = buf[rd_ptr]` (combinational read).
  - Issue condition: `fifo_count + inflight < 2`. When met, `rd_ptr` increments and the issue/last flags are delayed one cycle to match the quant stage register.
  - The delayed flag pushes `{q_unit, q_act_res, last}` into a 2-entry result FIFO.
  - After issuing element `len-1`, go to DRAIN.
- DRAIN: when the FIFO is empty and nothing is in flight, pulse `o_done` and go to IDLE.
- Output: `o_valid` = FIFO non-empty. `o_unit`, `o_activation` and `o_last` reflect the FIFO head. The head pops on `o_valid & o_ready`.
- `i_start` outside IDLE is ignored. `i_valid` outside LOAD is ignored.
- Simultaneous push and pop on the FIFO: count is unchanged and there is no data loss.
- Reset mid-tile: state, pointers, FIFO, flags and max are all cleared and the partial tile is discarded. The quant stage's active-low reset is tied to `~reset` at the top level.

## Timing
- Reset values: `o_in_ready`, `o_valid`, `o_last`, `o_busy`, `o_done` = 0. `q_max`, `q_act`, `o_unit`, `o_activation` = 0.
- `i_start` at cycle t: LOAD from t+1, `o_in_ready` is high at t+1.
- Last input accepted at cycle u: REPLAY at u+1, first issue at u+1, first `o_valid` at u+2.
- With `o_ready` held high, throughput is 1 result per cycle. Tile latency is `len + 2` cycles from the last input to `o_done`.
- `o_done` asserts in the cycle after the final pop. `o_busy` falls together with `o_done`.
- `o_valid` must stay high and its data must stay stable until the pop.

## Configuration
- `QUANT_TILE_SEQ_SIGN_EN`:
  - Defined: a port `o_sign` (out, 1) carries `i_data[31]` of each element, stored in the buffer and result FIFO and aligned with `o_activation`.
  - Undefined: the port, storage bit and FIFO bit are absent; behaviour is otherwise identical.

## Structure
- Shared package `quant_pkg` holds:
  - the state enum `{S_IDLE, S_LOAD, S_REPLAY, S_DRAIN}`;
  - `FP_EXP_MSB = 30`, `FP_MAG_MSB = 30`;
  - the FIFO depth constant `RES_FIFO_DEPTH = 2`.
- One sub-module: `quant_res_fifo`, a 2-entry synchronous FIFO with count output, parameterised on width.
- `quant_pre` is instantiated by the parent, not inside this block.

## Test plan
- `len=1`, data `0x3F800000` -> `q_max=0x3F800000`; one result with `o_unit=0x40000000`, `o_activation=0x80000000`, `o_last=1`; `o_done` pulses.
- `len=3`, data `0x3F800000`, `0x3F000000`, `0x3B000000` -> activations `0x80000000`, `0x40000000`, `0x00000000`. The third result has unit `0x00000008` and `o_last=1`.
- `len=2`, data `0xC0000000`, `0x3F800000` -> max selects `0xC0000000` (magnitude compare); activations `0x80000000` then `0x40000000`.
- `len=8` with `o_ready` toggling 1,0,0,1,... -> all 8 results arrive in order with none lost or duplicated, `o_valid` data is stable while stalled, and issue never exceeds 2 outstanding.
- `len=0` -> `o_done` one cycle after `i_start`, no `o_valid`. A second `i_start` during LOAD is ignored.
- `reset` asserted in REPLAY after 3 of 6 results -> all outputs at reset values next cycle; a new `len=1` tile then completes correctly.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared types and constants for the activation quantisation tile sequencer.
package quant_pkg;

  // Tile sequencer states
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_REPLAY,
    S_DRAIN
  } state_e;

  // fp32 field boundaries: bit 31 is the sign, bits 30:0 the magnitude
  localparam int FP_EXP_MSB = 30;
  localparam int FP_MAG_MSB = 30;

  // Result FIFO depth; the issue throttle keeps at most this many results outstanding
  localparam int RES_FIFO_DEPTH = 2;

  // Unsigned magnitude compare of two fp32 words, ignoring the sign bit
  function automatic logic mag_gt(input logic [31:0] a, input logic [31:0] b);
    return a[FP_MAG_MSB:0] > b[FP_MAG_MSB:0];
  endfunction

endpackage

// File: rtl/quant_tile_seq_if.sv
// Result stream (valid/ready) of the tile sequencer.
// QUANT_TILE_SEQ_SIGN_EN adds o_sign, the input sign bit aligned with o_activation.
interface quant_tile_seq_if;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_unit;
  logic [31:0] o_activation;
  logic        o_last;
`ifdef QUANT_TILE_SEQ_SIGN_EN
  logic        o_sign;

  modport master (output o_valid, o_unit, o_activation, o_last, o_sign, input o_ready);
  modport slave  (input o_valid, o_unit, o_activation, o_last, o_sign, output o_ready);
`else
  modport master (output o_valid, o_unit, o_activation, o_last, input o_ready);
  modport slave  (input o_valid, o_unit, o_activation, o_last, output o_ready);
`endif
endinterface

// File: rtl/quant_res_fifo.sv
// Two-entry synchronous result FIFO with occupancy count.
// Push and pop in the same cycle keep the count and lose no data, even when full.
module quant_res_fifo
  import quant_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [RES_FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Qualify push/pop and advance pointers and count
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(RES_FIFO_DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < RES_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/quant_tile_seq.sv
// Two-pass tile sequencer: loads a tile while tracking the largest magnitude,
// then replays it through quant_pre (one register stage, instantiated by the parent)
// and streams the results out. QUANT_TILE_SEQ_SIGN_EN adds o_sign on the result stream.
module quant_tile_seq
  import quant_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [AW:0]      i_len,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  output logic             o_in_ready,
  output logic [31:0]      q_max,
  output logic [31:0]      q_act,
  input  logic [31:0]      q_unit,
  input  logic [31:0]      q_act_res,
  output logic             o_busy,
  output logic             o_done,
  quant_tile_seq_if.master res
);

`ifdef QUANT_TILE_SEQ_SIGN_EN
  localparam int RW = 66;
`else
  localparam int RW = 65;
`endif
  localparam logic [AW:0] CNT_ONE = 1;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic [31:0]   max_q, max_d;
  logic          issue_q, issue_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          tile_we;
  logic [31:0]   tile_mem [DEPTH];
  logic [31:0]   rd_word;
  logic [1:0]    fifo_count;
  logic [RW-1:0] fifo_dout, push_word, head_word;
  logic          fifo_push, fifo_pop, head_valid, pop_any, accept, drained;
  logic [2:0]    outstanding;

  assign rd_word = tile_mem[rd_cnt_q[AW-1:0]];

`ifdef QUANT_TILE_SEQ_SIGN_EN
  // Sign of the issued element travels alongside the quant stage register
  logic sign_q, sign_d;
  assign sign_d = rd_word[31];
  always_ff @(posedge clk) begin
    if (reset) sign_q <= 1'b0;
    else       sign_q <= sign_d;
  end
  assign push_word = {q_unit, q_act_res, last_q, sign_q};
  assign res.o_sign = head_word[0];
`else
  assign push_word = {q_unit, q_act_res, last_q};
`endif

  // Result presented one cycle after issue: an empty FIFO passes the quant
  // output straight through, otherwise the FIFO head is shown
  always_comb begin
    head_valid  = (fifo_count != 2'd0) || issue_q;
    pop_any     = head_valid && res.o_ready;
    fifo_pop    = (fifo_count != 2'd0) && res.o_ready;
    fifo_push   = issue_q && !((fifo_count == 2'd0) && res.o_ready);
    head_word   = '0;
    if (fifo_count != 2'd0) head_word = fifo_dout;
    else if (issue_q)       head_word = push_word;
    outstanding = 3'(fifo_count) + 3'(issue_q) - 3'(pop_any);
    drained     = (outstanding == 3'd0);
    accept      = i_valid && (state_q == S_LOAD);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    max_d    = max_q;
    issue_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    tile_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d    = i_len;
          max_d    = '0;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          if (i_len == '0) done_d  = 1'b1;
          else             state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          tile_we  = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          // Strictly greater only, so ties keep the earlier word
          if (mag_gt(i_data, max_q)) max_d = i_data;
          if (wr_cnt_q == len_q - CNT_ONE) state_d = S_REPLAY;
        end
      end
      S_REPLAY: begin
        if ((3'(fifo_count) + 3'(issue_q)) < 3'(RES_FIFO_DEPTH)) begin
          issue_d  = 1'b1;
          last_d   = (rd_cnt_q == len_q - CNT_ONE);
          rd_cnt_d = rd_cnt_q + CNT_ONE;
          if (last_d) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers, max and issue pipeline flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      max_q    <= '0;
      issue_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      max_q    <= max_d;
      issue_q  <= issue_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  // Tile buffer; contents are meaningless until rewritten by the next LOAD
  always_ff @(posedge clk) begin
    if (tile_we) tile_mem[wr_cnt_q[AW-1:0]] <= i_data;
  end

  quant_res_fifo #(.W(RW)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_word),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign o_in_ready       = (state_q == S_LOAD);
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;
  assign q_max            = max_q;
  assign q_act            = (state_q == S_REPLAY) ? rd_word : 32'h0;
  assign res.o_valid      = head_valid;
  assign res.o_unit       = head_word[RW-1 -: 32];
  assign res.o_activation = head_word[RW-33 -: 32];
  assign res.o_last       = head_word[RW-65];

endmodule

// File: tb/tb_quant_tile_seq.sv
// Directed bench for quant_tile_seq with a stand-in quant_pre register stage.
// Checks QUANT_TILE_SEQ_SIGN_EN's o_sign when that macro is defined.
module tb_quant_tile_seq;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [AW:0]   i_len = '0;
  logic          i_valid = 1'b0;
  logic [31:0]   i_data = '0;
  logic          o_in_ready, o_busy, o_done;
  logic [31:0]   q_max, q_act;
  logic [31:0]   q_unit, q_act_res;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  quant_tile_seq_if res_if ();

  quant_tile_seq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_in_ready (o_in_ready),
    .q_max      (q_max),
    .q_act      (q_act),
    .q_unit     (q_unit),
    .q_act_res  (q_act_res),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .res        (res_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in quant_pre: exponent gap d between max and activation gives
  // activation 0x80000000>>d and unit 0x40000000>>d; d>=8 gives 0 and unit 8
  function automatic int exp_gap(input logic [31:0] m, input logic [31:0] a);
    int d;
    d = int'(m[30:23]) - int'(a[30:23]);
    if (d < 0) d = 0;
    return d;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q_unit    <= '0;
      q_act_res <= '0;
    end else if (exp_gap(q_max, q_act) >= 8) begin
      q_unit    <= 32'h0000_0008;
      q_act_res <= 32'h0;
    end else begin
      q_unit    <= 32'h4000_0000 >> exp_gap(q_max, q_act);
      q_act_res <= 32'h8000_0000 >> exp_gap(q_max, q_act);
    end
  end

  typedef struct {
    int                len;
    bit                stall;
    bit                restart;
    logic [31:0]       max;
    logic [63:0][31:0] data;
    logic [63:0][31:0] unit;
    logic [63:0][31:0] act;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void set_e(input int i, input int k, input logic [31:0] d,
                                input logic [31:0] u, input logic [31:0] a);
    tbl[i].data[k] = d;
    tbl[i].unit[k] = u;
    tbl[i].act[k]  = a;
  endfunction

  function automatic void set_v(input int i, input int len, input bit stall,
                                input bit restart, input logic [31:0] mx);
    tbl[i].len     = len;
    tbl[i].stall   = stall;
    tbl[i].restart = restart;
    tbl[i].max     = mx;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(o_in_ready), 0);
    check({tag, "_valid"}, 32'(res_if.o_valid), 0);
    check({tag, "_last"}, 32'(res_if.o_last), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_q_max"}, q_max, 0);
    check({tag, "_q_act"}, q_act, 0);
    check({tag, "_unit"}, res_if.o_unit, 0);
    check({tag, "_activation"}, res_if.o_activation, 0);
  endtask

  task automatic run_tile(input int idx, input vec_t v);
    int u, got, first_v, done_c;
    bit prev_stall, finished;
    logic [31:0] pu, pa;
    logic pl;
    u = 0; got = 0; first_v = -1; done_c = -1;
    prev_stall = 0; finished = 0; pu = '0; pa = '0; pl = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = 7'(v.len);
    @(posedge clk); #1;
    i_start = 1'b0;
    check("load_in_ready", 32'(o_in_ready), 1);
    check("load_busy", 32'(o_busy), 1);
    for (int k = 0; k < v.len; k++) begin
      i_valid = 1'b1;
      i_data  = v.data[k];
      u       = cyc;
      if (v.restart) begin
        i_start = (k == 0);
        i_len   = 7'd5;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    i_data  = 32'h7F7F_FFFF;
    for (int c = 0; c < 400 && !finished; c++) begin
      res_if.o_ready = v.stall ? (c % 3 == 0) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid_held", 32'(res_if.o_valid), 1);
        check("stall_unit_stable", res_if.o_unit, pu);
        check("stall_act_stable", res_if.o_activation, pa);
        check("stall_last_stable", 32'(res_if.o_last), 32'(pl));
      end
      if (res_if.o_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          check("q_max", q_max, v.max);
        end
        if (res_if.o_ready) begin
          if (got < v.len) begin
            $display("tile %0d result %0d unit=%08h act=%08h last=%0d",
                     idx, got, res_if.o_unit, res_if.o_activation, res_if.o_last);
            check("unit", res_if.o_unit, v.unit[got]);
            check("activation", res_if.o_activation, v.act[got]);
            check("last", 32'(res_if.o_last), 32'(got == v.len - 1));
`ifdef QUANT_TILE_SEQ_SIGN_EN
            check("sign", 32'(res_if.o_sign), 32'(v.data[got][31]));
`endif
          end
          got++;
        end
      end
      prev_stall = res_if.o_valid && !res_if.o_ready;
      pu = res_if.o_unit;
      pa = res_if.o_activation;
      pl = res_if.o_last;
      if (o_done) begin
        done_c   = cyc;
        finished = 1;
        check("done_busy_low", 32'(o_busy), 0);
        check("done_valid_low", 32'(res_if.o_valid), 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    check("result_count", 32'(got), 32'(v.len));
    check("first_valid_cycle", 32'(first_v), 32'(u + 2));
    if (!v.stall) check("tile_latency", 32'(done_c), 32'(u + v.len + 2));
    @(negedge clk);
    check("done_one_cycle", 32'(o_done), 0);
    res_if.o_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    res_if.o_ready = 1'b0;

    // Table: len=1, descending len=3, sign-magnitude max, stalled len=8,
    // equal magnitudes with an ignored restart, full-depth tile
    set_v(0, 1, 0, 0, 32'h3F80_0000);
    set_e(0, 0, 32'h3F80_0000, 32'h4000_0000, 32'h8000_0000);
    set_v(1, 3, 0, 0, 32'h3F80_0000);
    set_e(1, 0, 32'h3F80_0000, 32'h4000_0000, 32'h8000_0000);
    set_e(1, 1, 32'h3F00_0000, 32'h2000_0000, 32'h4000_0000);
    set_e(1, 2, 32'h3B00_0000, 32'h0000_0008, 32'h0000_0000);
    set_v(2, 2, 0, 0, 32'hC000_0000);
    set_e(2, 0, 32'hC000_0000, 32'h4000_0000, 32'h8000_0000);
    set_e(2, 1, 32'h3F80_0000, 32'h2000_0000, 32'h4000_0000);
    set_v(3, 8, 1, 0, 32'h3F80_0000);
    set_e(3, 0, 32'h3F00_0000, 32'h2000_0000, 32'h4000_0000);
    set_e(3, 1, 32'h3F80_0000, 32'h4000_0000, 32'h8000_0000);
    set_e(3, 2, 32'h3E80_0000, 32'h1000_0000, 32'h2000_0000);
    set_e(3, 3, 32'hBE00_0000, 32'h0800_0000, 32'h1000_0000);
    set_e(3, 4, 32'h3D80_0000, 32'h0400_0000, 32'h0800_0000);
    set_e(3, 5, 32'h3D00_0000, 32'h0200_0000, 32'h0400_0000);
    set_e(3, 6, 32'hBC80_0000, 32'h0100_0000, 32'h0200_0000);
    set_e(3, 7, 32'h3C00_0000, 32'h0080_0000, 32'h0100_0000);
    set_v(4, 2, 0, 1, 32'hBF80_0000);
    set_e(4, 0, 32'hBF80_0000, 32'h4000_0000, 32'h8000_0000);
    set_e(4, 1, 32'h3F80_0000, 32'h4000_0000, 32'h8000_0000);
    set_v(5, 64, 0, 0, 32'h4000_0000);
    for (int k = 0; k < 63; k++) set_e(5, k, 32'h3F80_0000, 32'h2000_0000, 32'h4000_0000);
    set_e(5, 63, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // i_valid while idle must not start anything
    i_valid = 1'b1;
    i_data  = 32'h7F7F_FFFF;
    @(negedge clk);
    check("idle_valid_in_ready", 32'(o_in_ready), 0);
    check("idle_valid_busy", 32'(o_busy), 0);
    i_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_tile(i, tbl[i]);

    // Zero-length tile: done on the next cycle, no results
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(o_done), 1);
    check("len0_busy", 32'(o_busy), 0);
    check("len0_valid", 32'(res_if.o_valid), 0);
    check("len0_in_ready", 32'(o_in_ready), 0);
    @(negedge clk);
    check("len0_done_drop", 32'(o_done), 0);

    // Reset during REPLAY after three of six results
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = 7'd6;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_data  = 32'h3F80_0000;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    res_if.o_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && got < 3; c++) begin
      @(negedge clk);
      if (res_if.o_valid && res_if.o_ready) got++;
      if (got < 3) begin
        @(posedge clk); #1;
      end
    end
    check("pre_reset_pops", 32'(got), 3);
    check("pre_reset_busy", 32'(o_busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    res_if.o_ready = 1'b0;
    run_tile(6, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
